// File: rtl/mf_pll_rst_seq.sv
// mf_pll_rst_seq: PLL lock qualifier and core reset sequencer.
// The asynchronous PLL lock flag is synchronised, then must stay high for
// LOCK_HOLD consecutive cycles before the downstream core leaves reset.
// While running, a single-cycle clock enable is produced every CE_DIV cycles.
// Optional feature macro: PLL_LOSS_COUNT_EN adds a saturating 8-bit counter
// of RUN -> WAIT_LOCK transitions on port lock_loss_cnt.
//
// State is one-hot-free binary in r_state: WAIT_LOCK=0, HOLD=1, RUN=2.
// Outputs core_rst, running and ce_out are pure decodes of registers, so they
// change on the same edge as the state they describe.
module mf_pll_rst_seq #(
    parameter int unsigned LOCK_HOLD = 1024,
    parameter int unsigned CE_DIV    = 6
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       pll_locked,
    output logic       core_rst,
    output logic       ce_out,
    output logic       running
`ifdef PLL_LOSS_COUNT_EN
    ,
    output logic [7:0] lock_loss_cnt
`endif
);

    localparam logic [1:0] ST_WAIT_LOCK = 2'd0;
    localparam logic [1:0] ST_HOLD      = 2'd1;
    localparam logic [1:0] ST_RUN       = 2'd2;

    localparam logic [15:0] HOLD_LAST = 16'(LOCK_HOLD - 1);
    localparam logic [7:0]  DIV_LAST  = 8'(CE_DIV - 1);

    logic        r_sync1;
    logic        r_lock_s;
    logic [1:0]  r_state;
    logic [15:0] r_hold_cnt;
    logic [7:0]  r_div_cnt;
    logic        w_in_run;

    assign w_in_run = (r_state == ST_RUN);

    // Two-flop synchroniser for the asynchronous lock flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1  <= 1'b0;
            r_lock_s <= 1'b0;
        end else begin
            r_sync1  <= pll_locked;
            r_lock_s <= r_sync1;
        end
    end

    // Lock qualification FSM with its hold counter; any drop in HOLD restarts
    // the qualification from zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_WAIT_LOCK;
            r_hold_cnt <= 16'd0;
        end else begin
            case (r_state)
                ST_WAIT_LOCK: begin
                    r_hold_cnt <= 16'd0;
                    if (r_lock_s) begin
                        r_state <= ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    if (!r_lock_s) begin
                        r_state    <= ST_WAIT_LOCK;
                        r_hold_cnt <= 16'd0;
                    end else if (r_hold_cnt == HOLD_LAST) begin
                        r_state    <= ST_RUN;
                        r_hold_cnt <= 16'd0;
                    end else begin
                        r_hold_cnt <= r_hold_cnt + 16'd1;
                    end
                end
                ST_RUN: begin
                    r_hold_cnt <= 16'd0;
                    if (!r_lock_s) begin
                        r_state <= ST_WAIT_LOCK;
                    end
                end
                default: begin
                    r_state    <= ST_WAIT_LOCK;
                    r_hold_cnt <= 16'd0;
                end
            endcase
        end
    end

    // Clock-enable divider: free-runs only while staying in RUN, and is
    // cleared on the edge that leaves RUN so re-entry starts from zero.
    always_ff @(posedge clk) begin
        if (rst || !w_in_run || !r_lock_s) begin
            r_div_cnt <= 8'd0;
        end else if (r_div_cnt == DIV_LAST) begin
            r_div_cnt <= 8'd0;
        end else begin
            r_div_cnt <= r_div_cnt + 8'd1;
        end
    end

    assign core_rst = !w_in_run;
    assign running  = w_in_run;
    assign ce_out   = w_in_run && (r_div_cnt == DIV_LAST);

`ifdef PLL_LOSS_COUNT_EN
    logic [7:0] r_loss_cnt;

    // Count lock losses out of RUN only; saturates at 255.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_loss_cnt <= 8'd0;
        end else if (w_in_run && !r_lock_s && (r_loss_cnt != 8'hFF)) begin
            r_loss_cnt <= r_loss_cnt + 8'd1;
        end
    end

    assign lock_loss_cnt = r_loss_cnt;
`endif

endmodule

// File: doc/mf_pll_rst_seq.md
MF_PLL_RST_SEQ -- requirements
Module: mf_pll_rst_seq

Interface
REQ-001 The block SHALL have parameter LOCK_HOLD, default 1024, the number of consecutive cycles of synchronised lock required before core reset releases (legal range 1..65535).
REQ-002 The block SHALL have parameter CE_DIV, default 6, the clock-enable divide ratio; 20 MHz / 6 = 3.333 MHz (legal range 2..255).
REQ-003 clk  input  1  system clock, the PLL 20 MHz outclk_0; all logic SHALL be on its rising edge.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 pll_locked  input  1  PLL locked flag, asynchronous to clk.
REQ-006 core_rst  output  1  active-high reset to the downstream core.
REQ-007 ce_out  output  1  single-cycle clock-enable pulse, one every CE_DIV cycles.
REQ-008 running  output  1  high while in state RUN.
REQ-009 lock_loss_cnt  output  8  saturating count of lock losses; present only when PLL_LOSS_COUNT_EN is defined.

Function
REQ-010 pll_locked SHALL pass through a two-flop synchroniser; its second-stage output is lock_s.
REQ-011 The FSM SHALL have three states: WAIT_LOCK, HOLD and RUN.
REQ-012 WAIT_LOCK: hold counter = 0; lock_s=1 -> HOLD on the next edge.
REQ-013 HOLD: hold counter increments once per cycle; lock_s=0 -> WAIT_LOCK with counter cleared; counter == LOCK_HOLD-1 with lock_s=1 -> RUN.
REQ-014 RUN: lock_s=0 -> WAIT_LOCK on the next edge; otherwise stay in RUN.
REQ-015 core_rst SHALL be 1 in every state except RUN and SHALL be decoded from the registered state (no extra latency).
REQ-016 running SHALL be 1 exactly when the state is RUN.
REQ-017 The divide counter SHALL be 0 in every state other than RUN; in RUN it counts 0..CE_DIV-1 and wraps to 0.
REQ-018 ce_out SHALL be 1 for exactly one cycle when the divide counter equals CE_DIV-1 in RUN, and 0 otherwise.
REQ-019 The first ce_out pulse SHALL occur in the CE_DIV-th cycle of RUN.
REQ-020 Total release latency: core_rst SHALL fall LOCK_HOLD+2 edges after the first edge that samples pll_locked=1, provided lock stays high throughout.
REQ-021 A lock glitch shorter than 2 cycles that is not captured by the synchroniser SHALL have no effect.
REQ-022 A glitch that is captured in HOLD SHALL restart the full LOCK_HOLD qualification.
REQ-023 Loss of lock in RUN SHALL drive core_rst=1, ce_out=0 and running=0 on the next edge.
REQ-024 The divide counter SHALL clear on loss of lock and SHALL restart from 0 on re-entry to RUN.

Reset
REQ-025 rst=1 SHALL force, on the next edge: synchroniser flops 0, state WAIT_LOCK, hold counter 0, divide counter 0.
REQ-026 After that edge the outputs SHALL be core_rst=1, ce_out=0 and running=0.
REQ-027 rst SHALL take priority over every other event, including mid-HOLD and mid-RUN.
REQ-028 lock_loss_cnt SHALL reset to 0 (when present).

Configuration
REQ-029 With macro PLL_LOSS_COUNT_EN defined, lock_loss_cnt SHALL increment by 1 on each RUN -> WAIT_LOCK transition.
REQ-030 The increment SHALL saturate at 255; HOLD aborts SHALL NOT count.
REQ-031 Without PLL_LOSS_COUNT_EN, the lock_loss_cnt port and its register SHALL be absent; all other behaviour SHALL be identical.

Verification
REQ-032 LOCK_HOLD=16, CE_DIV=6: rst for 3 cycles, then pll_locked held high -> core_rst falls exactly 18 edges after the first sampling edge; running rises on the same edge.
REQ-033 In RUN with CE_DIV=6: ce_out pulses in RUN cycles 6, 12 and 18, each pulse 1 cycle wide; 100 consecutive pulses are all 6 cycles apart.
REQ-034 LOCK_HOLD=16: pll_locked low for 3 cycles at HOLD count 10 -> state returns to WAIT_LOCK; after lock returns, release takes the full 18 edges from the new rise.
REQ-035 pll_locked dropped in RUN -> core_rst=1 and ce_out=0 within 3 edges; re-lock -> first ce_out occurs 6 cycles after running rises.
REQ-036 rst asserted for 1 cycle mid-RUN with lock high -> core_rst=1 on the next edge, then the release sequence is repeated (18 edges).
REQ-037 With PLL_LOSS_COUNT_EN defined: 300 RUN->loss cycles -> lock_loss_cnt reads 255; HOLD aborts leave it unchanged.
